// File: rtl/seg7_scan_counter_pkg.sv
// seg7_pkg: shared 7-segment definitions for the scanned counter.
//   - glyph constants, segment order {g,f,e,d,c,b,a}, active-high
//   - SEG_BLANK: all segments off
//   - seg7_glyph(digit): hex digit to glyph decode (A-F shown as b,C,d,E,F style)
package seg7_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t seg7_glyph(input digit_t digit);
        seg_t g;
        case (digit)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_counter_if.sv
// seg7_scan_counter_if: control and display bundle of the scanned counter.
//   master: controller side (drives en/up/clear/load/load_val, sees outputs)
//   slave : counter side
//   en, up, clear, load  control strobes/levels
//   load_val, count      packed digits, digit 0 in the LSBs
//   tick, wrap           one-cycle step / wrap pulses
//   seg_out, dig_sel     segments {g,f,e,d,c,b,a} and one-hot digit enable
interface seg7_scan_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    up;
    logic                    clear;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    tick;
    logic                    wrap;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_sel;

    modport master (
        output en, up, clear, load, load_val,
        input  count, tick, wrap, seg_out, dig_sel
    );

    modport slave (
        input  en, up, clear, load, load_val,
        output count, tick, wrap, seg_out, dig_sel
    );
endinterface

// File: rtl/seg7_scan_counter_tick_div.sv
// tick_div: terminal-count prescaler, one tc every DIV enabled cycles.
//   clk, rst  clock and synchronous active-high reset
//   en        counter advances while high, holds while low
//   restart   synchronous return to the start of a period (beats en)
//   tc        high in the enabled cycle that ends a period
// Implemented as a down-counter so tc is a compare against zero; this is
// cycle-equivalent to an up-counter running 0..DIV-1.
module tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tc
);
    localparam int            CW     = $clog2(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
        end
    end

    assign tc = en && (cnt == '0);
endmodule

// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: N-digit BCD/hex up/down counter with a step prescaler
// and a time-multiplexed 7-segment scanner.
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   seg7_scan_counter_if.slave (en, up, clear, load, load_val in;
//         count, tick, wrap, seg_out, dig_sel out)
// Build option: SEG7_LZ_BLANK_EN blanks leading zero digits (digit 0 is
// always shown); without it every digit shows its glyph.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int RADIX      = 16,
    parameter int TICK_DIV   = 10_000_000,
    parameter int SCAN_DIV   = 10_000
) (
    input  logic clk,
    input  logic rst,
    seg7_scan_counter_if.slave bus
);
    localparam int           CW    = 4 * NUM_DIGITS;
    localparam int           IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam digit_t       DMAX  = 4'(RADIX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                  step_tc;
    logic                  scan_tc;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         step_val;
    logic [CW-1:0]         load_clamped;
    logic                  step_carry;
    digit_t                dig_cur;
    logic                  tick_q;
    logic                  wrap_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_nxt;
    logic [NUM_DIGITS-1:0] sel_nxt;
    digit_t                shown_digit;
    seg_t                  seg_nxt;

    // Step prescaler restarts on clear/load so a new value gets a full period.
    tick_div #(.DIV(TICK_DIV)) u_step_div (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .restart (bus.clear | bus.load),
        .tc      (step_tc)
    );

    tick_div #(.DIV(SCAN_DIV)) u_scan_div (
        .clk     (clk),
        .rst     (rst),
        .en      (1'b1),
        .restart (1'b0),
        .tc      (scan_tc)
    );

    // Ripple carry/borrow across digits; a carry out of the top digit is a wrap.
    always_comb begin
        step_val   = cnt_q;
        step_carry = 1'b1;
        dig_cur    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_cur = cnt_q[4*i +: 4];
            if (step_carry) begin
                if (bus.up) begin
                    if (dig_cur == DMAX) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = dig_cur + 4'd1;
                        step_carry         = 1'b0;
                    end
                end else begin
                    if (dig_cur == 4'd0) begin
                        step_val[4*i +: 4] = DMAX;
                    end else begin
                        step_val[4*i +: 4] = dig_cur - 4'd1;
                        step_carry         = 1'b0;
                    end
                end
            end
        end
    end

    // Compare in 5 bits so the hex build does not reduce to a constant test.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ({1'b0, bus.load_val[4*i +: 4]} > 5'(RADIX - 1)) begin
                load_clamped[4*i +: 4] = DMAX;
            end else begin
                load_clamped[4*i +: 4] = bus.load_val[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.clear) begin
                cnt_q <= '0;
            end else if (bus.load) begin
                cnt_q <= load_clamped;
            end else if (step_tc) begin
                cnt_q  <= step_val;
                tick_q <= 1'b1;
                wrap_q <= step_carry;
            end
        end
    end

    assign bus.count = cnt_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;

    // Scanner. Select and glyph are both computed from the next index so
    // dig_sel and seg_out register on the same edge.
    always_comb begin
        idx_nxt = idx_q;
        if (scan_tc) begin
            idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        sel_nxt     = '0;
        shown_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                sel_nxt[i]  = 1'b1;
                shown_digit = cnt_q[4*i +: 4];
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lit;
    logic                  nz_seen;
    logic                  blank_nxt;

    // lit[i]: some digit at or above i is non-zero, so digit i is significant.
    always_comb begin
        lit     = '0;
        nz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (cnt_q[4*i +: 4] != 4'd0) begin
                nz_seen = 1'b1;
            end
            lit[i] = nz_seen;
        end
        lit[0] = 1'b1;
    end

    always_comb begin
        blank_nxt = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_nxt[i] && !lit[i]) begin
                blank_nxt = 1'b1;
            end
        end
        seg_nxt = blank_nxt ? SEG_BLANK : seg7_glyph(shown_digit);
    end
`else
    always_comb begin
        seg_nxt = seg7_glyph(shown_digit);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            bus.dig_sel <= NUM_DIGITS'(1);
            bus.seg_out <= SEG_0;
        end else begin
            idx_q       <= idx_nxt;
            bus.dig_sel <= sel_nxt;
            bus.seg_out <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_scan_counter.sv
// Bench for seg7_scan_counter: a 2-digit BCD instance and a 4-digit hex
// instance share one stimulus stream. A numeric reference model predicts
// every output on every cycle; directed phases pin the model to literals.
module tb_seg7_scan_counter;
    import seg7_pkg::*;

    localparam int TD = 4;
    localparam int SD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, up, clear, load;
    logic [15:0] lv;

    int n_pass  = 0;
    int n_total = 0;

    seg7_scan_counter_if #(.NUM_DIGITS(2)) bus_a ();
    seg7_scan_counter_if #(.NUM_DIGITS(4)) bus_b ();

    assign bus_a.en       = en;
    assign bus_a.up       = up;
    assign bus_a.clear    = clear;
    assign bus_a.load     = load;
    assign bus_a.load_val = lv[7:0];
    assign bus_b.en       = en;
    assign bus_b.up       = up;
    assign bus_b.clear    = clear;
    assign bus_b.load     = load;
    assign bus_b.load_val = lv;

    seg7_scan_counter #(.NUM_DIGITS(2), .RADIX(10), .TICK_DIV(TD), .SCAN_DIV(SD)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    seg7_scan_counter #(.NUM_DIGITS(4), .RADIX(16), .TICK_DIV(TD), .SCAN_DIV(SD)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Reference glyph table, index = digit value.
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_nd  [2] = '{2, 4};
    int          m_rad [2] = '{10, 16};
    int unsigned m_val [2];
    int unsigned m_pre [2];
    int unsigned m_k   [2];
    int unsigned m_tick[2];
    int unsigned m_wrap[2];
    int unsigned m_seg [2];
    int unsigned m_dig [2];
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned pw(input int unsigned r, input int e);
        int unsigned p = 1;
        for (int i = 0; i < e; i++) p = p * r;
        return p;
    endfunction

    function automatic int unsigned to_packed(input int unsigned v, input int r, input int nd);
        int unsigned res = 0;
        for (int i = 0; i < nd; i++) res = res | (((v / pw(r, i)) % r) << (4 * i));
        return res;
    endfunction

    function automatic int unsigned from_load(input int unsigned l, input int r, input int nd);
        int unsigned v = 0;
        int unsigned nib;
        for (int i = 0; i < nd; i++) begin
            nib = (l >> (4 * i)) & 32'hF;
            if (nib > r - 1) nib = r - 1;
            v = v + nib * pw(r, i);
        end
        return v;
    endfunction

    // Numeric model: the count is an integer modulo RADIX**NUM_DIGITS.
    always @(posedge clk) begin
        int          idx;
        int unsigned modv;
        int unsigned digit;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_val[d] = 0; m_pre[d] = 0; m_k[d] = 0;
                m_tick[d] = 0; m_wrap[d] = 0; m_seg[d] = 32'h3F; m_dig[d] = 1;
            end else begin
                modv     = pw(m_rad[d], m_nd[d]);
                m_k[d]   = (m_k[d] + 1) % (SD * m_nd[d]);
                idx      = int'(m_k[d]) / SD;
                m_dig[d] = 1 << idx;
                digit    = (m_val[d] / pw(m_rad[d], idx)) % m_rad[d];
                m_seg[d] = 32'(glyph_tab[digit]);
`ifdef SEG7_LZ_BLANK_EN
                if (idx > 0 && m_val[d] < pw(m_rad[d], idx)) m_seg[d] = 0;
`endif
                m_tick[d] = 0;
                m_wrap[d] = 0;
                if (clear) begin
                    m_val[d] = 0; m_pre[d] = 0;
                end else if (load) begin
                    m_val[d] = from_load(32'(lv), m_rad[d], m_nd[d]); m_pre[d] = 0;
                end else if (en) begin
                    if (m_pre[d] == TD - 1) begin
                        m_pre[d]  = 0;
                        m_tick[d] = 1;
                        if (up) begin
                            m_wrap[d] = (m_val[d] == modv - 1) ? 1 : 0;
                            m_val[d]  = (m_val[d] + 1) % modv;
                        end else begin
                            m_wrap[d] = (m_val[d] == 0) ? 1 : 0;
                            m_val[d]  = (m_val[d] + modv - 1) % modv;
                        end
                    end else begin
                        m_pre[d] = m_pre[d] + 1;
                    end
                end
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("a_count", 32'(bus_a.count),   to_packed(m_val[0], 10, 2));
            chk("a_tick",  32'(bus_a.tick),    m_tick[0]);
            chk("a_wrap",  32'(bus_a.wrap),    m_wrap[0]);
            chk("a_seg",   32'(bus_a.seg_out), m_seg[0]);
            chk("a_dig",   32'(bus_a.dig_sel), m_dig[0]);
            chk("b_count", 32'(bus_b.count),   to_packed(m_val[1], 16, 4));
            chk("b_tick",  32'(bus_b.tick),    m_tick[1]);
            chk("b_wrap",  32'(bus_b.wrap),    m_wrap[1]);
            chk("b_seg",   32'(bus_b.seg_out), m_seg[1]);
            chk("b_dig",   32'(bus_b.dig_sel), m_dig[1]);
        end
    end

    task automatic step_cyc();
        @(negedge clk);
        #1;
    endtask

    // Cycles until tick is seen on the BCD instance; 0 means it never came.
    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step_cyc();
            if (bus_a.tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        lv   = v;
        load = 1'b1;
        step_cyc();
        load = 1'b0;
    endtask

    initial begin
        int          n;
        logic [3:0]  prev;
        bit          found;
        int unsigned exp_d3;

        rst = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; lv = '0;
        repeat (3) step_cyc();
        chk("rst_count", 32'(bus_a.count), 32'h00);
        chk("rst_seg",   32'(bus_a.seg_out), 32'h3F);
        chk("rst_dig",   32'(bus_a.dig_sel), 32'h1);
        chk("rst_tick",  32'(bus_a.tick), 32'h0);

        rst = 1'b0; en = 1'b1;
        wait_tick(n);
        chk("first_tick_lat", 32'(n), 32'd4);
        chk("first_tick_cnt", 32'(bus_a.count), 32'h01);

        repeat (2) step_cyc();
        en = 1'b0;
        repeat (10) step_cyc();
        en = 1'b1;
        wait_tick(n);
        chk("hold_lat", 32'(n), 32'd2);
        chk("hold_cnt", 32'(bus_a.count), 32'h02);

        up = 1'b1;
        do_load(16'h0099);
        wait_tick(n);
        chk("bcd_up_lat",  32'(n), 32'd4);
        chk("bcd_up_cnt",  32'(bus_a.count), 32'h00);
        chk("bcd_up_wrap", 32'(bus_a.wrap), 32'h1);
        chk("hex_up_cnt",  32'(bus_b.count), 32'h009A);

        up = 1'b0;
        do_load(16'h0010);
        wait_tick(n);
        chk("bcd_dn_cnt",  32'(bus_a.count), 32'h09);
        chk("bcd_dn_wrap", 32'(bus_a.wrap), 32'h0);

        do_load(16'h0000);
        wait_tick(n);
        chk("hex_dn_cnt",  32'(bus_b.count), 32'hFFFF);
        chk("hex_dn_wrap", 32'(bus_b.wrap), 32'h1);
        chk("bcd_dn_max",  32'(bus_a.count), 32'h99);

        repeat (3) step_cyc();
        do_load(16'h00C3);
        chk("clamp_cnt",  32'(bus_a.count), 32'h93);
        chk("clamp_tick", 32'(bus_a.tick), 32'h0);
        chk("hexld_cnt",  32'(bus_b.count), 32'h00C3);
        clear = 1'b1; load = 1'b1;
        step_cyc();
        clear = 1'b0; load = 1'b0;
        chk("clear_cnt_a", 32'(bus_a.count), 32'h0);
        chk("clear_cnt_b", 32'(bus_b.count), 32'h0);

        en = 1'b0;
        do_load(16'h0120);
        prev  = bus_b.dig_sel;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step_cyc();
            if (bus_b.dig_sel == 4'h1 && prev != 4'h1) begin
                found = 1'b1;
                break;
            end
            prev = bus_b.dig_sel;
        end
        chk("scan_found", 32'(found), 32'h1);
`ifdef SEG7_LZ_BLANK_EN
        exp_d3 = 32'h00;
`else
        exp_d3 = 32'h3F;
`endif
        chk("scan_d0_sel", 32'(bus_b.dig_sel), 32'h1);
        chk("scan_d0_seg", 32'(bus_b.seg_out), 32'h3F);
        repeat (2) step_cyc();
        chk("scan_d0_hold", 32'(bus_b.dig_sel), 32'h1);
        step_cyc();
        chk("scan_d1_sel", 32'(bus_b.dig_sel), 32'h2);
        chk("scan_d1_seg", 32'(bus_b.seg_out), 32'h5B);
        repeat (3) step_cyc();
        chk("scan_d2_sel", 32'(bus_b.dig_sel), 32'h4);
        chk("scan_d2_seg", 32'(bus_b.seg_out), 32'h06);
        repeat (3) step_cyc();
        chk("scan_d3_sel", 32'(bus_b.dig_sel), 32'h8);
        chk("scan_d3_seg", 32'(bus_b.seg_out), exp_d3);

        for (int i = 0; i < 4000; i++) begin
            step_cyc();
            rst   = ($urandom_range(0, 499) == 0);
            en    = ($urandom_range(0, 9) != 0);
            up    = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 79) == 0);
            load  = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 4))
                0:       lv = 16'hFFFF;
                1:       lv = 16'h0000;
                2:       lv = 16'h9999;
                3:       lv = 16'hFFFE;
                default: lv = 16'($urandom);
            endcase
        end
        rst = 1'b0; clear = 1'b0; load = 1'b0;
        repeat (2) step_cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seg7_scan_counter.md
# seg7_scan_counter

Parametrised N-digit up/down counter with a programmable time-base prescaler and a time-multiplexed 7-segment display driver. It generalises the single-digit free-running hex display counter to configurable digit count, radix (BCD or hex), direction, load/clear control and a digit scanner. It sits between the board-level display pins (segments plus digit enables) and any control logic supplying enable, direction and load values.

## Interface
- `NUM_DIGITS`, default 4: number of digits, range 1–8.
- `RADIX`, default 16: per-digit radix, either 10 (BCD) or 16 (hex).
- `TICK_DIV`, default 10_000_000: clock cycles per count step, ≥2.
- `SCAN_DIV`, default 10_000: clock cycles per scanned digit, ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: prescaler runs while high and holds while low.
- `up` in 1: 1 = count up, 0 = count down; sampled on each step.
- `clear` in 1: synchronous clear of count and prescaler.
- `load` in 1: synchronous load of `load_val`.
- `load_val` in 4*NUM_DIGITS: packed digits, digit 0 in the LSBs.
- `count` out 4*NUM_DIGITS: current packed count; reset value 0.
- `tick` out 1: one-cycle pulse when a count step was applied; reset value 0.
- `wrap` out 1: one-cycle pulse when the step wrapped (max→0 up, 0→max down); reset value 0.
- `seg_out` out 7: segments {g,f,e,d,c,b,a}, active-high; reset value 7'h3F (the glyph "0").
- `dig_sel` out NUM_DIGITS: one-hot digit enable, active-high; reset value 1 (digit 0).

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1 while `en`=1. A step is taken when `en`=1 and `pre`==TICK_DIV-1; `pre` then returns to 0.
- Step up: digit 0 increments. Any digit reaching RADIX-1 rolls to 0 and carries to the next digit. All digits at RADIX-1 → all 0, and `wrap` is asserted.
- Step down: mirror image with borrow. All digits at 0 → all RADIX-1, and `wrap` is asserted.
- Priority, highest first: `rst`, `clear`, `load`, step.
  - `clear`: `count`=0, `pre`=0, no `tick`.
  - `load`: `count`=`load_val`, `pre`=0, no `tick`. Any digit ≥RADIX is clamped to RADIX-1.
- Scanner: free-running `scan_pre` counts 0..SCAN_DIV-1 independently of `en`, `clear` and `load`.
  - On terminal count, digit index `idx` advances 0→1→…→NUM_DIGITS-1→0.
  - `dig_sel` is the one-hot decode of `idx`.
  - `seg_out` is the registered glyph decode of digit `idx` of `count`. Hex glyphs A–F are b,C,d,E,F style. With RADIX=10, only 0–9 can occur.
- NUM_DIGITS=1: `idx` stays 0 and `dig_sel` is constantly 1.

## Timing
- `count`, `tick` and `wrap` update on the same edge as the step. `tick`/`wrap` are high for exactly the following cycle, aligned with the new `count`.
- With `en` held high from reset release, the first `tick` appears TICK_DIV cycles after release, then every TICK_DIV cycles.
- Dropping `en` freezes `pre`. Re-raising `en` resumes from the held value, with no lost or extra step.
- `load`/`clear` asserted in a step cycle: the step is discarded, and `tick`/`wrap` stay 0.
- `dig_sel` and `seg_out` change together on the same edge. `seg_out` reflects `count` with 1-cycle latency.
- `rst` mid-operation: all state returns to reset values on the next edge, regardless of other inputs.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digits above the most significant non-zero digit drive `seg_out`=0 while selected.
  - Digit 0 is never blanked.
  - `dig_sel` is unaffected.
- Undefined: every digit shows its glyph, zeros included.

## Structure
- Shared package `seg7_pkg` holds:
  - the 7-bit segment glyph constants;
  - the `seg7_glyph(digit)` decode function;
  - the `SEG_BLANK` constant.
- One sub-module, `tick_div`: a parametrised terminal-count prescaler with an enable and a synchronous restart. It is instantiated twice, as the step prescaler (gated by `en`, restarted by `clear`/`load`) and as the scan prescaler (always enabled).

## Test plan
- Reset/step: NUM_DIGITS=2, RADIX=10, TICK_DIV=4, `en`=1 after reset. Require `count`=8'h00 and `seg_out`=7'h3F at reset. First `tick` 4 cycles after release, with `count`=8'h01.
- BCD carry/wrap: load 8'h99, up, one step → `count`=8'h00, `tick`=1 and `wrap`=1 in the same cycle. Load 8'h10, down → 8'h09 with `wrap`=0.
- Hex down-wrap: RADIX=16, load 8'h00, `up`=0, one step → 8'hFF, `wrap`=1.
- Priority/clamp: assert `load`=1 with `load_val`=8'hC3, RADIX=10, in the step cycle → `count`=8'h93, `tick`=0. Assert `clear` with `load` → `count`=0.
- Enable hold: drop `en` for 10 cycles at `pre`=2 (TICK_DIV=4). The next `tick` occurs 2 cycles after `en` rises.
- Scan: NUM_DIGITS=4, SCAN_DIV=3, `count`=16'h0120 → `dig_sel` cycles 1,2,4,8 every 3 cycles.
  - `seg_out` is 7'h3F, 7'h5B, 7'h06, 7'h3F.
  - With `SEG7_LZ_BLANK_EN`, digit 3 shows 0.
